// File: rtl/id_ex_ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_ctrl_pipe_pkg
// Shared definitions for the ID/EX control stage: opcode and R-type funct
// encodings, the 3-bit base ALU control codes (zero-extended by users when
// ALU_CTRL_W > 3), the link register index and the control-bit bundle that
// travels from the decoder into the EX pipeline register.
// No ports; imported by id_ex_ctrl_pipe and id_ex_ctrl_pipe_main_decoder.
// -----------------------------------------------------------------------------
package id_ex_ctrl_pipe_pkg;

    localparam int INSTR_W = 32;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct field, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Base ALU control codes
    localparam int         ALU_BASE_W = 3;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b100;

    // JAL writes the return address here
    localparam int LINK_REG = 31;

    // Single-bit controls carried into EX
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic branch_ne;
        logic jump;
        logic link;
        logic illegal;
    } ctrl_bits_t;

    localparam ctrl_bits_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_ctrl_pipe_main_decoder.sv
// -----------------------------------------------------------------------------
// id_ex_ctrl_pipe_main_decoder
// Purely combinational instruction decoder for the ID/EX control stage.
// Ports:
//   instr     in   32          instruction word from IF/ID
//   ctrl      out  ctrl_bits_t single-bit controls, including the illegal flag
//   alu_ctrl  out  ALU_CTRL_W  ALU control code (zero-extended base code)
//   wr_addr   out  REG_ADDR_W  resolved destination register (0 if no write)
//   rs, rt    out  REG_ADDR_W  source register fields
//   uses_rt   out  1           instruction reads rt as an operand
// -----------------------------------------------------------------------------
module id_ex_ctrl_pipe_main_decoder
    import id_ex_ctrl_pipe_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5,
    parameter bit EN_EXT_OPS = 1'b1
) (
    input  logic [INSTR_W-1:0]    instr,
    output ctrl_bits_t            ctrl,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic                  uses_rt
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rd;
    logic                  unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rs           = REG_ADDR_W'(instr[25:21]);
    assign rt           = REG_ADDR_W'(instr[20:16]);
    assign rd           = REG_ADDR_W'(instr[15:11]);
    assign unused_shamt = ^instr[10:6];

    // Control table. Everything defaults to "no effect"; each opcode only
    // raises the controls it needs. Extension opcodes fall through to
    // illegal when EN_EXT_OPS is clear so the hardware simply disappears.
    always_comb begin
        ctrl     = CTRL_NONE;
        alu_ctrl = ALU_CTRL_W'(ALU_NOP);
        wr_addr  = '0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt        = 1'b1;
                ctrl.reg_write = 1'b1;
                wr_addr        = rd;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_CTRL_W'(ALU_ADD);
                    FN_SUB:  alu_ctrl = ALU_CTRL_W'(ALU_SUB);
                    FN_AND:  alu_ctrl = ALU_CTRL_W'(ALU_AND);
                    FN_OR:   alu_ctrl = ALU_CTRL_W'(ALU_OR);
                    FN_SLT:  alu_ctrl = ALU_CTRL_W'(ALU_SLT);
                    default: begin
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                        wr_addr        = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctrl       = ALU_CTRL_W'(ALU_ADD);
                wr_addr        = rt;
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctrl       = ALU_CTRL_W'(ALU_AND);
                wr_addr        = rt;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                alu_ctrl        = ALU_CTRL_W'(ALU_ADD);
                wr_addr         = rt;
            end
            OP_SW: begin
                uses_rt        = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctrl       = ALU_CTRL_W'(ALU_ADD);
            end
            OP_BEQ: begin
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                alu_ctrl    = ALU_CTRL_W'(ALU_SUB);
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_ORI: begin
                if (EN_EXT_OPS) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    alu_ctrl       = ALU_CTRL_W'(ALU_OR);
                    wr_addr        = rt;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EN_EXT_OPS) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    alu_ctrl       = ALU_CTRL_W'(ALU_SLT);
                    wr_addr        = rt;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_BNE: begin
                if (EN_EXT_OPS) begin
                    uses_rt        = 1'b1;
                    ctrl.branch_ne = 1'b1;
                    alu_ctrl       = ALU_CTRL_W'(ALU_SUB);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                if (EN_EXT_OPS) begin
                    ctrl.jump      = 1'b1;
                    ctrl.link      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    wr_addr        = REG_ADDR_W'(LINK_REG);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_ctrl_pipe
// Decode plus ID/EX pipeline register for the control path. Decodes the IF/ID
// instruction, detects load-use hazards, handles hold/flush and registers the
// control bundle into EX with one cycle of latency. Counts illegal
// instructions accepted into EX with a saturating counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_valid        id_instr holds a real instruction
//   id_instr        32-bit instruction word
//   hold            downstream stall, freezes the stage
//   flush           taken branch/jump, kill the ID instruction
//   stall_id        load-use stall request to IF/ID
//   ex_*            registered EX-stage controls, addresses and flags
//   ill_count       saturating illegal-instruction count
// -----------------------------------------------------------------------------
module id_ex_ctrl_pipe
    import id_ex_ctrl_pipe_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5,
    parameter bit EN_EXT_OPS = 1'b1,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [INSTR_W-1:0]    id_instr,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_branch_ne,
    output logic                  ex_jump,
    output logic                  ex_link,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [REG_ADDR_W-1:0] ex_wr_addr,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  ex_illegal,
    output logic [ILL_CNT_W-1:0]  ill_count
);

    ctrl_bits_t            dec_ctrl;
    logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
    logic [REG_ADDR_W-1:0] dec_wr_addr;
    logic [REG_ADDR_W-1:0] dec_rs;
    logic [REG_ADDR_W-1:0] dec_rt;
    logic                  dec_uses_rt;

    logic                  ex_valid_q,    ex_valid_d;
    ctrl_bits_t            ex_ctrl_q,     ex_ctrl_d;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl_q, ex_alu_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_wr_addr_q,  ex_wr_addr_d;
    logic [REG_ADDR_W-1:0] ex_rs_q,       ex_rs_d;
    logic [REG_ADDR_W-1:0] ex_rt_q,       ex_rt_d;
    logic                  flush_pend_q,  flush_pend_d;
    logic [ILL_CNT_W-1:0]  ill_count_q,   ill_count_d;

    logic                  load_use;

    id_ex_ctrl_pipe_main_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W),
        .REG_ADDR_W (REG_ADDR_W),
        .EN_EXT_OPS (EN_EXT_OPS)
    ) u_main_decoder (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .alu_ctrl (dec_alu_ctrl),
        .wr_addr  (dec_wr_addr),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .uses_rt  (dec_uses_rt)
    );

    // Load-use hazard: the load in EX produces a value the ID instruction
    // reads. Writes to register 0 are discarded, so they never hazard.
    // While hold is asserted IF/ID is frozen anyway, so the request is masked.
    always_comb begin
        load_use = ex_valid_q && ex_ctrl_q.mem_read && (ex_wr_addr_q != '0)
                   && id_valid
                   && ((ex_wr_addr_q == dec_rs)
                       || (dec_uses_rt && (ex_wr_addr_q == dec_rt)));
        stall_id = load_use && !hold;
    end

    // Next EX contents. Hold keeps every register and only remembers a flush
    // so it can be applied on the first free edge. Any other edge starts from
    // a bubble and loads the decoded instruction only if nothing kills it.
    // flush_pend is always consumed on a non-hold edge.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_alu_ctrl_d = ex_alu_ctrl_q;
        ex_wr_addr_d  = ex_wr_addr_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        flush_pend_d  = flush_pend_q;
        ill_count_d   = ill_count_q;
        if (hold) begin
            if (flush) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            ex_valid_d    = 1'b0;
            ex_ctrl_d     = CTRL_NONE;
            ex_alu_ctrl_d = ALU_CTRL_W'(ALU_NOP);
            ex_wr_addr_d  = '0;
            ex_rs_d       = '0;
            ex_rt_d       = '0;
            flush_pend_d  = 1'b0;
            if (!flush && !flush_pend_q && !load_use && id_valid) begin
                ex_valid_d = 1'b1;
                if (dec_ctrl.illegal) begin
                    // Illegal instructions travel as a marked bubble
                    ex_ctrl_d.illegal = 1'b1;
                    if (ill_count_q != '1) begin
                        ill_count_d = ill_count_q + ILL_CNT_W'(1);
                    end
                end else begin
                    ex_ctrl_d     = dec_ctrl;
                    ex_alu_ctrl_d = dec_alu_ctrl;
                    ex_wr_addr_d  = dec_wr_addr;
                    ex_rs_d       = dec_rs;
                    ex_rt_d       = dec_rt;
                end
            end
        end
    end

    // EX pipeline register, pending-flush flag and illegal counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= CTRL_NONE;
            ex_alu_ctrl_q <= ALU_CTRL_W'(ALU_NOP);
            ex_wr_addr_q  <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            flush_pend_q  <= 1'b0;
            ill_count_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_alu_ctrl_q <= ex_alu_ctrl_d;
            ex_wr_addr_q  <= ex_wr_addr_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            flush_pend_q  <= flush_pend_d;
            ill_count_q   <= ill_count_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_branch_ne  = ex_ctrl_q.branch_ne;
    assign ex_jump       = ex_ctrl_q.jump;
    assign ex_link       = ex_ctrl_q.link;
    assign ex_illegal    = ex_ctrl_q.illegal;
    assign ex_alu_ctrl   = ex_alu_ctrl_q;
    assign ex_wr_addr    = ex_wr_addr_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ill_count     = ill_count_q;

endmodule
